// File: rtl/vend_ctrl.sv
// ============================================================================
// Module   : vend_ctrl
// Brief    : Coin-operated single-item vending controller. Accumulates
//            nickel/dime/quarter credit in nickel units, pulses open for one
//            cycle per sale and tracks stock. With CHANGE_RETURN_EN defined,
//            excess credit and cancelled credit are paid out as change_nickel
//            pulses; otherwise excess credit carries toward the next item.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_ctrl #(
    parameter int PRICE_N    = 5,
    parameter int CREDIT_W   = 7,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                restock,
    output logic                open,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [STOCK_W-1:0]  stock,
    output logic                sold_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_PAYOUT = 2'd3;

`ifdef CHANGE_RETURN_EN
    localparam bit c_CHG_EN = 1'b1;
`else
    localparam bit c_CHG_EN = 1'b0;
`endif

    localparam logic [CREDIT_W-1:0] c_PRICE      = CREDIT_W'(PRICE_N);
    localparam logic [CREDIT_W-1:0] c_CR_ZERO    = '0;
    localparam logic [CREDIT_W-1:0] c_CR_ONE     = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] c_CR_NICKEL  = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] c_CR_DIME    = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] c_CR_QUARTER = CREDIT_W'(5);
    localparam logic [STOCK_W-1:0]  c_STOCK_INIT = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0]  c_STOCK_ONE  = STOCK_W'(1);
    localparam logic [STOCK_W-1:0]  c_STOCK_ZERO = '0;

    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [STOCK_W-1:0]  r_stock;
    logic                r_reject;

    logic [1:0]          w_coin_cnt;
    logic                w_any_coin;
    logic                w_one_coin;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_credit_sum;
    logic [CREDIT_W-1:0] w_remain;
    logic                w_cancel_acc;

    // Classify the coin inputs: only a lone coin is a valid deposit.
    assign w_coin_cnt   = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};
    assign w_any_coin   = nickel | dime | quarter;
    assign w_one_coin   = (w_coin_cnt == 2'd1);
    assign w_credit_sum = r_credit + w_coin_val;
    assign w_remain     = r_credit - c_PRICE;
    // Refunds only make sense with credit held and change hardware present.
    assign w_cancel_acc = cancel & c_CHG_EN & (r_state == S_ACCUM);

    // Coin value in nickel units; only meaningful when a single coin is high.
    always_comb begin
        w_coin_val = c_CR_ZERO;
        if (nickel)
            w_coin_val = c_CR_NICKEL;
        else if (dime)
            w_coin_val = c_CR_DIME;
        else if (quarter)
            w_coin_val = c_CR_QUARTER;
    end

    // Main controller: state, credit, stock and the coin-refused pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_credit <= c_CR_ZERO;
            r_stock  <= c_STOCK_INIT;
            r_reject <= 1'b0;
        end else begin
            r_reject <= 1'b0;
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (restock)
                        r_stock <= c_STOCK_INIT;
                    if (w_cancel_acc) begin
                        // Cancel wins over a coin arriving in the same cycle.
                        r_reject <= w_any_coin;
                        r_state  <= S_PAYOUT;
                    end else if (w_any_coin) begin
                        // Acceptance looks at stock before any restock lands.
                        if (!w_one_coin || (r_stock == c_STOCK_ZERO)) begin
                            r_reject <= 1'b1;
                        end else begin
                            r_credit <= w_credit_sum;
                            r_state  <= (w_credit_sum >= c_PRICE) ? S_VEND : S_ACCUM;
                        end
                    end
                end
                S_VEND: begin
                    r_reject <= w_any_coin;
                    r_credit <= w_remain;
                    r_stock  <= r_stock - c_STOCK_ONE;
                    if (w_remain == c_CR_ZERO)
                        r_state <= S_IDLE;
                    else if (c_CHG_EN)
                        r_state <= S_PAYOUT;
                    else
                        r_state <= S_ACCUM;
                end
`ifdef CHANGE_RETURN_EN
                S_PAYOUT: begin
                    r_reject <= w_any_coin;
                    if (r_credit <= c_CR_ONE) begin
                        r_credit <= c_CR_ZERO;
                        r_state  <= S_IDLE;
                    end else begin
                        r_credit <= r_credit - c_CR_ONE;
                    end
                end
`endif
                default: begin
                    r_state  <= S_IDLE;
                    r_credit <= c_CR_ZERO;
                end
            endcase
        end
    end

    assign open = (r_state == S_VEND);
`ifdef CHANGE_RETURN_EN
    assign change_nickel = (r_state == S_PAYOUT);
`else
    assign change_nickel = 1'b0;
`endif
    assign coin_reject = r_reject;
    assign credit      = r_credit;
    assign stock       = r_stock;
    assign sold_out    = (r_stock == c_STOCK_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl.sv
// ============================================================================
// Module   : tb_vend_ctrl
// Brief    : Self-checking bench for vend_ctrl: directed vector table,
//            hand-written corner sequences and randomized traffic against a
//            behavioural model. Expectations follow CHANGE_RETURN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_ctrl;

    localparam int PRICE_N    = 5;
    localparam int CREDIT_W   = 7;
    localparam int STOCK_W    = 4;
    localparam int STOCK_INIT = 10;

`ifdef CHANGE_RETURN_EN
    localparam bit MAC = 1'b1;
`else
    localparam bit MAC = 1'b0;
`endif

    logic clk, rst;
    logic nickel, dime, quarter, cancel, restock;
    logic open, change_nickel, coin_reject, sold_out;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W-1:0]  stock;

    int n_chk = 0;
    int n_err = 0;

    vend_ctrl #(
        .PRICE_N   (PRICE_N),
        .CREDIT_W  (CREDIT_W),
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .nickel       (nickel),
        .dime         (dime),
        .quarter      (quarter),
        .cancel       (cancel),
        .restock      (restock),
        .open         (open),
        .change_nickel(change_nickel),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .stock        (stock),
        .sold_out     (sold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample 1 later.
    task automatic cyc(input bit n, input bit d, input bit q, input bit c, input bit rs);
        @(negedge clk);
        nickel = n; dime = d; quarter = q; cancel = c; restock = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_credit"}, 32'(credit), 0);
        chk({tag, "_stock"},  32'(stock), STOCK_INIT);
        chk({tag, "_open"},   32'(open), 0);
        chk({tag, "_change"}, 32'(change_nickel), 0);
        chk({tag, "_reject"}, 32'(coin_reject), 0);
        chk({tag, "_soldout"}, 32'(sold_out), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nickel = 0; dime = 0; quarter = 0; cancel = 0; restock = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    int m_credit, m_stock;
    bit m_vend, m_pay, m_rej;

    task automatic model_reset();
        m_credit = 0; m_stock = STOCK_INIT; m_vend = 0; m_pay = 0; m_rej = 0;
    endtask

    // One clock edge of the vending rules in plain arithmetic.
    task automatic model_step(input bit n, input bit d, input bit q, input bit c, input bit rs);
        int ncoins, val, old_stock;
        ncoins = int'(n) + int'(d) + int'(q);
        val    = int'(n) * 1 + int'(d) * 2 + int'(q) * 5;
        m_rej  = 0;
        if (m_vend) begin
            m_vend   = 0;
            m_credit = m_credit - PRICE_N;
            m_stock  = m_stock - 1;
            m_pay    = MAC && (m_credit > 0);
            m_rej    = (ncoins > 0);
        end else if (m_pay) begin
            m_credit = m_credit - 1;
            m_pay    = (m_credit > 0);
            m_rej    = (ncoins > 0);
        end else begin
            old_stock = m_stock;
            if (rs) m_stock = STOCK_INIT;
            if (MAC && c && m_credit > 0) begin
                m_pay = 1;
                m_rej = (ncoins > 0);
            end else if (ncoins > 1) begin
                m_rej = 1;
            end else if (ncoins == 1) begin
                if (old_stock == 0) begin
                    m_rej = 1;
                end else begin
                    m_credit = m_credit + val;
                    m_vend   = (m_credit >= PRICE_N);
                end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit n, d, q, c, rs;
        int cr_on, cr_off;
        bit op, chg_on, rej;
        int stk;
    } vec_t;

    vec_t vt[11];

    initial begin
        int e_cr;
        rst = 1'b0;
        nickel = 0; dime = 0; quarter = 0; cancel = 0; restock = 0;

        //            n  d  q  c  rs cr_on cr_off op chg rej stk
        vt[0]  = '{0, 1, 0, 0, 0, 2, 2, 0, 0, 0, 10};
        vt[1]  = '{0, 1, 0, 0, 0, 4, 4, 0, 0, 0, 10};
        vt[2]  = '{1, 0, 0, 0, 0, 5, 5, 1, 0, 0, 10};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9};
        vt[4]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 9};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9};
        vt[6]  = '{0, 1, 0, 0, 0, 2, 2, 0, 0, 0, 9};
        vt[7]  = '{0, 0, 1, 0, 0, 7, 7, 1, 0, 0, 9};
        vt[8]  = '{0, 0, 1, 0, 0, 2, 2, 0, 1, 1, 8};
        vt[9]  = '{0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 8};
        vt[10] = '{0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 8};

        // Asynchronous reset must act before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        do_reset();

        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].n, vt[i].d, vt[i].q, vt[i].c, vt[i].rs);
            e_cr = MAC ? vt[i].cr_on : vt[i].cr_off;
            chk($sformatf("vec%0d_credit", i), 32'(credit), e_cr);
            chk($sformatf("vec%0d_open", i), 32'(open), vt[i].op);
            chk($sformatf("vec%0d_change", i), 32'(change_nickel), MAC & vt[i].chg_on);
            chk($sformatf("vec%0d_reject", i), 32'(coin_reject), vt[i].rej);
            chk($sformatf("vec%0d_stock", i), 32'(stock), vt[i].stk);
        end

        // ---- nickel x3, cancel, reset during the second payout cycle ----
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("n3_credit", 32'(credit), 3);
        cyc(0, 0, 0, 1, 0);
        chk("cancel_change1", 32'(change_nickel), MAC);
        chk("cancel_credit1", 32'(credit), 3);
        cyc(0, 0, 0, 0, 0);
        chk("cancel_change2", 32'(change_nickel), MAC);
        chk("cancel_credit2", 32'(credit), MAC ? 2 : 3);
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_payout");
        @(posedge clk);
        #1;
        chk("rst_hold_change", 32'(change_nickel), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk($sformatf("post_rst_change%0d", i), 32'(change_nickel), 0);
            chk($sformatf("post_rst_open%0d", i), 32'(open), 0);
        end

        // ---- cancel and coin in the same cycle while accumulating ----
        do_reset();
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        chk("cancel_coin_reject", 32'(coin_reject), MAC);
        chk("cancel_coin_credit", 32'(credit), MAC ? 2 : 4);
        chk("cancel_coin_change", 32'(change_nickel), MAC);

        // ---- exhaust stock, refused coin, restock ----
        do_reset();
        for (int i = 0; i < STOCK_INIT; i++) begin
            cyc(0, 0, 1, 0, 0);
            chk($sformatf("sale%0d_open", i), 32'(open), 1);
            cyc(0, 0, 0, 0, 0);
            chk($sformatf("sale%0d_stock", i), 32'(stock), STOCK_INIT - 1 - i);
        end
        chk("soldout_flag", 32'(sold_out), 1);
        cyc(0, 1, 0, 0, 0);
        chk("soldout_reject", 32'(coin_reject), 1);
        chk("soldout_credit", 32'(credit), 0);
        cyc(0, 0, 0, 0, 1);
        chk("restock_stock", 32'(stock), STOCK_INIT);
        chk("restock_soldout", 32'(sold_out), 0);

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit n, d, q, c, rs;
            int r;
            r = int'($urandom_range(0, 99));
            n = 0; d = 0; q = 0;
            if (r < 12)      n = 1;
            else if (r < 22) d = 1;
            else if (r < 30) q = 1;
            else if (r < 34) begin n = 1; q = 1; end
            else if (r < 36) begin n = 1; d = 1; q = 1; end
            c  = ($urandom_range(0, 14) == 0);
            rs = ($urandom_range(0, 59) == 0);
            cyc(n, d, q, c, rs);
            model_step(n, d, q, c, rs);
            chk($sformatf("rnd%0d_credit", i), 32'(credit), m_credit);
            chk($sformatf("rnd%0d_stock", i), 32'(stock), m_stock);
            chk($sformatf("rnd%0d_open", i), 32'(open), m_vend);
            chk($sformatf("rnd%0d_change", i), 32'(change_nickel), m_pay);
            chk($sformatf("rnd%0d_reject", i), 32'(coin_reject), m_rej);
            chk($sformatf("rnd%0d_soldout", i), 32'(sold_out), (m_stock == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
